pwm_car_axi_slave: RTL and testbench
====================================

# pwm_car_axi_slave

AXI4-Lite slave that terminates the register transactions issued by the processor-side AXI master (and by the master BFM in block-level simulation), and drives two PWM motor channels for the car. Four 32-bit read/write registers set enables, directions, PWM period and per-wheel duty. The PWM outputs go to the motor driver pins at the top level.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data bus width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width. Bits [3:2] select the register.
- PWM_WIDTH, 16: width of the PWM counter, period and duty fields.

Ports (clock and reset first):
- ACLK  in  1  single clock; everything is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accepted.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data accepted.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response accepted.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accepted.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00 (OKAY).
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data accepted.
- pwm_l, pwm_r  out  1 each  left and right motor PWM.
- dir_l, dir_r  out  1 each  left and right motor direction.

## Operation
Register map (byte offsets):
- 0x0 CTRL: [0] en_l, [1] en_r, [2] dir_l, [3] dir_r.
- 0x4 PERIOD: [15:0] period.
- 0x8 DUTY_L: [15:0] duty.
- 0xC DUTY_R: [15:0] duty.
- All 32 bits of every register are stored. A read returns exactly the last value written, including unused bits.

Write channel:
- States: IDLE, RESP.
- In IDLE, when AWVALID and WVALID are both high: assert AWREADY and WREADY together for one cycle, and commit WDATA byte-wise under WSTRB on that same edge. Then go to RESP.
- AW arriving without W (or W without AW) is held. Neither ready asserts until both are present.
- In RESP, BVALID is high. It stays high until BREADY is sampled high, then the FSM returns to IDLE. No new write is accepted while in RESP.

Read channel:
- States: IDLE, DATA.
- In IDLE with ARVALID high: pulse ARREADY for one cycle and latch the addressed register into RDATA. Go to DATA.
- In DATA, RVALID is high and RDATA is held stable until RREADY is sampled high.
- The read and write channels run independently. If a read is accepted on the same edge as a write commit to the same register, RDATA returns the pre-write value.

PWM:
- A free-running counter cnt runs 0..period−1 and wraps to 0.
- Period and duty are copied into shadow registers only when cnt wraps (and at the first enable), so there are no glitches mid-cycle.
- pwm_x = en_x & (cnt < duty_x_shadow), registered.
- duty ≥ period gives a constant high while enabled. duty = 0 gives a constant low.
- period_shadow = 0: cnt is held at 0 and both PWM outputs are low.
- dir_x is driven straight from CTRL (registered), independent of enable.

## Timing
- Reset values: all registers 0, AWREADY/WREADY/ARREADY/BVALID/RVALID = 0, RDATA = 0, BRESP/RRESP = 0, pwm_* = 0, dir_* = 0, cnt = 0. Reset is asynchronous on assertion.
- ARESET asserted mid-transaction aborts it: any pending B or R is dropped and no partial write remains.
- Write timing:
  - AWREADY/WREADY pulse in the cycle after both valids are first seen high.
  - BVALID rises on the next cycle.
  - Minimum spacing between back-to-back writes (BREADY tied high) is 3 cycles.
- Read timing:
  - ARREADY pulses the cycle after ARVALID is first seen high.
  - RVALID rises on the next cycle.
  - Minimum spacing with RREADY tied high is 3 cycles.
- PWM timing:
  - The output is registered: 1 cycle behind cnt.
  - A new period or duty takes effect at the first wrap after the register write commits.
  - Output period is exactly `period` ACLK cycles.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0/0x4/0x8/0xC, reading back after each: every read equals the written value, and every BRESP/RRESP = 0.
- Write 0xFFFFFFFF to 0x8, then 0x00000000 with WSTRB=4'b0010: readback is 0xFFFF00FF.
- Drive WVALID 5 cycles before AWVALID, hold BREADY low for 4 cycles: AWREADY and WREADY pulse together once, BVALID stays high until BREADY, and a second write issued during that hold is not accepted.
- PERIOD=10, DUTY_L=3, DUTY_R=12, CTRL=0x3: pwm_l is high 3 of every 10 cycles and pwm_r is constantly high. Changing DUTY_L to 7 mid-cycle takes effect only after the next wrap.
- PERIOD=0 with CTRL=0xF: pwm_l/pwm_r stay 0 and dir_l/dir_r = 1.
- Assert ARESET while BVALID=1 and RVALID=1: all outputs return to reset values immediately, and reading 0x0 afterwards returns 0.

Source files
------------

// File: rtl/pwm_car_axi_slave_if.sv
// AXI4-Lite register bus between the processor-side master and the PWM car slave.
// Carries only the five AXI channels; clock and reset stay as plain ports.
interface pwm_car_axi_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/pwm_car_axi_slave.sv
// AXI4-Lite slave with four 32-bit registers driving two glitch-free PWM motor channels.
// Ready pulses one cycle after valid(s) seen, response the cycle after; B/R held until BREADY/RREADY.
module pwm_car_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_WIDTH          = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  pwm_car_axi_slave_if.slave   s_axi,
  output logic                 pwm_l,
  output logic                 pwm_r,
  output logic                 dir_l,
  output logic                 dir_r
);

  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic                          aw_rdy, ar_rdy, b_vld, r_vld;
  logic                          wr_fire, rd_fire;
  logic [1:0]                    wr_sel, rd_sel;

  assign wr_sel  = s_axi.S_AXI_AWADDR[3:2];
  assign rd_sel  = s_axi.S_AXI_ARADDR[3:2];
  assign wr_fire = aw_rdy & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = ar_rdy & s_axi.S_AXI_ARVALID;

  assign s_axi.S_AXI_AWREADY = aw_rdy;
  assign s_axi.S_AXI_WREADY  = aw_rdy;
  assign s_axi.S_AXI_BVALID  = b_vld;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = ar_rdy;
  assign s_axi.S_AXI_RVALID  = r_vld;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RDATA   = rdata;

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_fire) wr_next = WR_RESP;
      WR_RESP: if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    b_vld = (wr_state == WR_RESP);
  end

  // AW and W are accepted together, and only once both are present.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) aw_rdy <= 1'b0;
    else        aw_rdy <= (wr_state == WR_IDLE) & s_axi.S_AXI_AWVALID
                          & s_axi.S_AXI_WVALID & ~aw_rdy;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NUM_BYTES; b++)
        if (s_axi.S_AXI_WSTRB[b]) regs[wr_sel][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_fire) rd_next = RD_DATA;
      RD_DATA: if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    r_vld = (rd_state == RD_DATA);
  end

  // RDATA samples regs on the accept edge, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_rdy <= 1'b0;
      rdata  <= '0;
    end else begin
      ar_rdy <= (rd_state == RD_IDLE) & s_axi.S_AXI_ARVALID & ~ar_rdy;
      if (rd_fire) rdata <= regs[rd_sel];
    end
  end

  // ---------------- PWM ----------------
  logic [PWM_WIDTH-1:0] cnt, period_sh, duty_l_sh, duty_r_sh;
  logic                 en_l, en_r, en_any_q, load;

  assign en_l = regs[0][0];
  assign en_r = regs[0][1];

  // Shadows refresh only at wrap or on a fresh enable; period 0 reloads every cycle.
  assign load = (period_sh == '0) || (cnt == period_sh - PWM_WIDTH'(1))
                || ((en_l | en_r) & ~en_any_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt       <= '0;
      period_sh <= '0;
      duty_l_sh <= '0;
      duty_r_sh <= '0;
      en_any_q  <= 1'b0;
      pwm_l     <= 1'b0;
      pwm_r     <= 1'b0;
      dir_l     <= 1'b0;
      dir_r     <= 1'b0;
    end else begin
      en_any_q <= en_l | en_r;
      if (load) begin
        cnt       <= '0;
        period_sh <= regs[1][PWM_WIDTH-1:0];
        duty_l_sh <= regs[2][PWM_WIDTH-1:0];
        duty_r_sh <= regs[3][PWM_WIDTH-1:0];
      end else begin
        cnt <= cnt + PWM_WIDTH'(1);
      end
      pwm_l <= en_l & (period_sh != '0) & (cnt < duty_l_sh);
      pwm_r <= en_r & (period_sh != '0) & (cnt < duty_r_sh);
      dir_l <= regs[0][2];
      dir_r <= regs[0][3];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pwm_car_axi_slave.sv
// Directed bench for pwm_car_axi_slave: register readback, strobes, handshake holds, PWM shape, reset abort.
module tb_pwm_car_axi_slave;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic pwm_l, pwm_r, dir_l, dir_r;
  int   tests = 0;
  int   fails = 0;

  pwm_car_axi_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  pwm_car_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .PWM_WIDTH(16)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axi  (bus.slave),
    .pwm_l  (pwm_l),
    .pwm_r  (pwm_r),
    .dir_l  (dir_l),
    .dir_r  (dir_r)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin tick(1); n++; end
    check("wr_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick(1);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin tick(1); n++; end
    check("wr_bvalid_bresp", 32'({bus.S_AXI_BVALID, bus.S_AXI_BRESP}), 32'b100);
    tick(1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin tick(1); n++; end
    check("rd_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    tick(1);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin tick(1); n++; end
    check("rd_rvalid_rresp", 32'({bus.S_AXI_RVALID, bus.S_AXI_RRESP}), 32'b100);
    d = bus.S_AXI_RDATA;
    tick(1);
  endtask

  logic [31:0] wvals [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

  initial begin
    logic [31:0] rd;
    logic        prev;
    int          n, hi_l, hi_r;

    bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0;  bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0;  bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0;  bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    tick(3);
    check("reset_ctrl", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                             bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP,
                             bus.S_AXI_RRESP, pwm_l, pwm_r, dir_l, dir_r}), 32'd0);
    check("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    ARESET = 1'b0;
    tick(1);

    // Full-word write then readback on each register
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(4 * i), wvals[i], 4'hF);
      axi_read(4'(4 * i), rd);
      check("readback", rd, wvals[i]);
    end

    // Byte strobe: only byte 1 cleared
    axi_write(4'h8, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h8, 32'h00000000, 4'b0010);
    axi_read(4'h8, rd);
    check("wstrb_byte1", rd, 32'hFFFF00FF);

    // W ahead of AW, then a long BREADY hold with a second write pending
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWADDR  = 4'h8;
    bus.S_AXI_WDATA   = 32'h11111111;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("w_only_no_ready", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'd0);
    end
    bus.S_AXI_AWVALID = 1'b1;
    tick(1);
    check("aw_w_pulse", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}), 32'b110);
    tick(1);
    check("aw_w_single", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}), 32'b001);
    bus.S_AXI_AWADDR = 4'hC;
    bus.S_AXI_WDATA  = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("b_hold_no_accept", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}), 32'b001);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick(1);
    check("b_released", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}), 32'b000);
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin tick(1); n++; end
    check("second_wr_accept", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick(1);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    tick(1);
    axi_read(4'h8, rd);
    check("first_wr_data", rd, 32'h11111111);
    axi_read(4'hC, rd);
    check("second_wr_data", rd, 32'h22222222);

    // PWM: period 10, left duty 3, right duty 12 (saturates high)
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd12, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    tick(12);
    hi_l = 0;
    hi_r = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      hi_l += int'(pwm_l);
      hi_r += int'(pwm_r);
    end
    check("pwm_l_3of10", 32'(hi_l), 32'd6);
    check("pwm_r_const", 32'(hi_r), 32'd20);
    check("dir_ctrl3", 32'({dir_l, dir_r}), 32'd0);

    // Align to cnt=0, change duty mid-cycle: old duty holds until the wrap
    prev = pwm_l;
    n = 0;
    while (n < 30) begin
      tick(1);
      n++;
      if (!prev && pwm_l) break;
      prev = pwm_l;
    end
    check("pwm_l_rise_found", 32'(pwm_l), 32'd1);
    axi_write(4'h8, 32'd7, 4'hF);
    check("duty_old_cnt3", 32'(pwm_l), 32'd0);
    hi_l = 0;
    for (int i = 0; i < 6; i++) begin tick(1); hi_l += int'(pwm_l); end
    check("duty_old_tail", 32'(hi_l), 32'd0);
    hi_l = 0;
    for (int i = 0; i < 10; i++) begin tick(1); hi_l += int'(pwm_l); end
    check("duty_new_7of10", 32'(hi_l), 32'd7);

    // Period 0 forces outputs low; directions still follow CTRL
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'hF, 4'hF);
    tick(15);
    hi_l = 0;
    for (int i = 0; i < 10; i++) begin tick(1); hi_l += int'(pwm_l) + int'(pwm_r); end
    check("period0_low", 32'(hi_l), 32'd0);
    check("period0_dir", 32'({dir_l, dir_r}), 32'b11);

    // Reset while both B and R are pending
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_WDATA   = 32'h5;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARADDR  = 4'h0;
    bus.S_AXI_ARVALID = 1'b1;
    tick(1);
    check("abort_readys", 32'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 32'b11);
    tick(1);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check("abort_pending", 32'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 32'b11);
    check("abort_rdata_pre", bus.S_AXI_RDATA, 32'hF);
    ARESET = 1'b1;
    #1;
    check("abort_outs", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                             bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP,
                             bus.S_AXI_RRESP, pwm_l, pwm_r, dir_l, dir_r}), 32'd0);
    check("abort_rdata", bus.S_AXI_RDATA, 32'd0);
    tick(2);
    ARESET = 1'b0;
    tick(1);
    axi_read(4'h0, rd);
    check("post_reset_ctrl", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
